// File: rtl/osd_spi_tx.sv
// osd_spi_tx: SPI master streaming OSD enable commands and 256-byte line payloads to the OSD slave.
// Build option: define OSD_TX_CLEAR_EN to enable the clear-line command (op 10); otherwise op 10 is dropped.
module osd_spi_tx #(
    parameter logic [7:0] CLK_DIV = 8'd4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_arg,
    output logic       data_req,
    output logic [7:0] data_addr,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DROP,
        ST_FETCH,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [1:0] OP_ENABLE = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [7:0] HALF_LAST = CLK_DIV - 8'd1;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [8:0] byte_q, byte_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] op_q, op_d;
    logic [7:0] addr_q, addr_d;
    logic       req_q, req_d;
    logic       ready_q;
    logic       sck_q;
    logic       ss_q;
    logic       busy_q;
    logic       clear_en_s;
    logic       cnt_done_s;
    logic       last_byte_s;

`ifdef OSD_TX_CLEAR_EN
    assign clear_en_s = 1'b1;
`else
    assign clear_en_s = 1'b0;
`endif

    assign cnt_done_s  = (cnt_q == 8'd0);
    // byte_q counts completed bytes; the command byte is byte 0, payload byte k is byte k+1
    assign last_byte_s = (op_q == OP_ENABLE) ? (byte_q == 9'd0) : (byte_q == 9'd256);

    // Next-state logic for the transfer sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_done_s ? cnt_q : (cnt_q - 8'd1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        op_d    = op_q;
        addr_d  = addr_q;
        req_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d   = cmd_op;
                    byte_d = 9'd0;
                    bit_d  = 3'd7;
                    cnt_d  = HALF_LAST;
                    case (cmd_op)
                        OP_ENABLE: begin
                            shift_d = {4'b0100, 3'b000, cmd_arg[0]};
                            state_d = ST_LOW;
                        end
                        OP_WRITE: begin
                            shift_d = {5'b00100, cmd_arg};
                            state_d = ST_LOW;
                        end
                        OP_CLEAR: begin
                            if (clear_en_s) begin
                                shift_d = {5'b00100, cmd_arg};
                                state_d = ST_LOW;
                            end else begin
                                state_d = ST_DROP;
                            end
                        end
                        default: state_d = ST_DROP;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: state_d = ST_IDLE;
            ST_FETCH: begin
                // data_in answers the strobe issued on the first FETCH cycle
                if (cnt_done_s) begin
                    shift_d = data_in;
                    cnt_d   = HALF_LAST;
                    state_d = ST_LOW;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_LOW: begin
                if (cnt_done_s) begin
                    cnt_d   = HALF_LAST;
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (cnt_done_s) begin
                    cnt_d   = HALF_LAST;
                    shift_d = {shift_q[6:0], 1'b0};
                    if (bit_q != 3'd0) begin
                        bit_d   = bit_q - 3'd1;
                        state_d = ST_LOW;
                    end else begin
                        byte_d = byte_q + 9'd1;
                        bit_d  = 3'd7;
                        if (last_byte_s) begin
                            state_d = ST_HOLD;
                        end else if (op_q == OP_WRITE) begin
                            cnt_d   = 8'd1;
                            req_d   = 1'b1;
                            addr_d  = byte_q[7:0];
                            state_d = ST_FETCH;
                        end else begin
                            shift_d = 8'h00;
                            state_d = ST_LOW;
                        end
                    end
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_HOLD: begin
                if (cnt_done_s) begin
                    cnt_d   = HALF_LAST;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (cnt_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs (outputs follow the state being entered)
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            byte_q  <= 9'd0;
            shift_q <= 8'h00;
            op_q    <= 2'b00;
            addr_q  <= 8'd0;
            req_q   <= 1'b0;
            ready_q <= 1'b0;
            sck_q   <= 1'b0;
            ss_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            ready_q <= (state_d == ST_IDLE);
            sck_q   <= (state_d == ST_HIGH);
            ss_q    <= !(state_d inside {ST_FETCH, ST_LOW, ST_HIGH, ST_HOLD});
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign cmd_ready = ready_q;
    assign data_req  = req_q;
    assign data_addr = addr_q;
    assign busy      = busy_q;
    assign SPI_SCK   = sck_q;
    assign SPI_SS3   = ss_q;
    assign SPI_DO    = shift_q[7];

endmodule

// File: tb/tb_osd_spi_tx.sv
// Scoreboard bench for osd_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=1) share a behavioural SPI slave monitor.
module tb_osd_spi_tx;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [2:0] cmd_arg;
    logic       sel;

    logic       ready0, req0, busy0, sck0, ss0, do0;
    logic       ready1, req1, busy1, sck1, ss1, do1;
    logic [7:0] addr0, addr1;
    logic [7:0] din0 = 8'h00;
    logic [7:0] din1 = 8'h00;

    logic       ready_m, req_m, busy_m, sck_m, ss_m, do_m;
    logic [7:0] addr_m;
    int         div_m;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         low_len = 0, high_len = 0, last_low = 0, last_high = 0;
    int         run = 0, bitc = 0, req_idx = 0, req_total = 0, ss_falls = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] e;
    logic       sck_p = 1'b0, ss_p = 1'b1, do_p = 1'b0;

    always #5 clk_sys = ~clk_sys;

    osd_spi_tx #(.CLK_DIV(8'd2)) dut2 (
        .clk_sys(clk_sys), .reset(reset), .cmd_valid(cmd_valid && !sel), .cmd_ready(ready0),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .data_req(req0), .data_addr(addr0), .data_in(din0),
        .busy(busy0), .SPI_SCK(sck0), .SPI_SS3(ss0), .SPI_DO(do0)
    );

    osd_spi_tx #(.CLK_DIV(8'd1)) dut1 (
        .clk_sys(clk_sys), .reset(reset), .cmd_valid(cmd_valid && sel), .cmd_ready(ready1),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .data_req(req1), .data_addr(addr1), .data_in(din1),
        .busy(busy1), .SPI_SCK(sck1), .SPI_SS3(ss1), .SPI_DO(do1)
    );

    assign ready_m = sel ? ready1 : ready0;
    assign req_m   = sel ? req1 : req0;
    assign addr_m  = sel ? addr1 : addr0;
    assign busy_m  = sel ? busy1 : busy0;
    assign sck_m   = sel ? sck1 : sck0;
    assign ss_m    = sel ? ss1 : ss0;
    assign do_m    = sel ? do1 : do0;
    assign div_m   = sel ? 1 : 2;

    // Synchronous payload source: byte = addr ^ 0xA5, valid the cycle after the strobe
    always @(posedge clk_sys) begin
        din0 <= req0 ? (addr0 ^ 8'hA5) : 8'h3C;
        din1 <= req1 ? (addr1 ^ 8'hA5) : 8'h3C;
    end

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] arg, input bit keep);
        int n;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        n = 0;
        while (!ready_m && n < 20000) begin
            tick();
            n++;
        end
        chk("accept_timeout", int'(ready_m), 1);
        tick();
        if (!keep) cmd_valid = 1'b0;
        chk("ready_after_accept", int'(ready_m), 0);
        chk("busy_after_accept", int'(busy_m), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!ready_m && n < 20000) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(ready_m), 1);
        chk("bytes_left", exp_q.size(), 0);
    endtask

    task automatic push_line(input logic [7:0] cmd, input bit zeros, input int count);
        exp_q.push_back(cmd);
        for (int i = 0; i < count; i++) begin
            e = zeros ? 8'h00 : (8'(i) ^ 8'hA5);
            exp_q.push_back(e);
        end
    endtask

    task automatic drop_check(input logic [1:0] op);
        int falls0, req0_cnt;
        falls0   = ss_falls;
        req0_cnt = req_total;
        issue(op, 3'd7, 1'b0);
        tick();
        chk("drop_ready_2cyc", int'(ready_m), 1);
        repeat (6) tick();
        chk("drop_no_ss", ss_falls - falls0, 0);
        chk("drop_no_req", req_total - req0_cnt, 0);
    endtask

    initial begin
        int base;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 3'd0;
        sel       = 1'b0;
        fork
            begin
                // Behavioural SPI slave and data_req monitor
                forever begin
                    @(negedge clk_sys);
                    if (req_m) begin
                        chk("data_addr", int'(addr_m), req_idx % 256);
                        req_idx++;
                        req_total++;
                    end
                    if (ss_m) begin
                        if (!ss_p) last_low = low_len;
                        high_len++;
                        low_len = 0;
                        bitc    = 0;
                        req_idx = 0;
                    end else begin
                        if (ss_p) begin
                            last_high = high_len;
                            high_len  = 0;
                            ss_falls++;
                        end
                        low_len++;
                        if (sck_m && !sck_p) begin
                            if (bitc != 0) chk("sck_low_len", run, div_m);
                            sh = {sh[6:0], do_m};
                            bitc++;
                            run = 1;
                            if (bitc == 8) begin
                                bitc = 0;
                                if (exp_q.size() == 0) begin
                                    chk("unexpected_byte", int'(sh), 256);
                                end else begin
                                    e = exp_q.pop_front();
                                    chk("spi_byte", int'(sh), int'(e));
                                end
                            end
                        end else if (!sck_m && sck_p) begin
                            chk("sck_high_len", run, div_m);
                            run = 1;
                        end else begin
                            run++;
                            if (sck_m) chk("do_stable", int'(do_m), int'(do_p));
                        end
                    end
                    sck_p = sck_m;
                    ss_p  = ss_m;
                    do_p  = do_m;
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", int'(ready_m), 0);
        chk("rst_ss3", int'(ss_m), 1);
        chk("rst_sck", int'(sck_m), 0);
        chk("rst_busy", int'(busy_m), 0);
        chk("rst_data_req", int'(req_m), 0);
        chk("rst_data_addr", int'(addr_m), 0);
        chk("rst_do", int'(do_m), 0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", int'(ready_m), 1);

        // T1: enable, single byte 0x41
        exp_q.push_back(8'h41);
        issue(2'b00, 3'd1, 1'b0);
        wait_idle();
        chk("t1_ss_low", last_low, 34);

        // T2: write line 5 with 256 fetched bytes
        push_line(8'h25, 1'b0, 256);
        base = req_total;
        issue(2'b01, 3'd5, 1'b0);
        wait_idle();
        chk("t2_req_count", req_total - base, 256);
        chk("t2_ss_low", last_low, 8738);

        // T3: back-to-back enable commands with cmd_valid held
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h40);
        issue(2'b00, 3'd1, 1'b1);
        issue(2'b00, 3'd0, 1'b0);
        wait_idle();
        chk("t3_ss_gap", int'(last_high >= 2), 1);
        chk("t3_ss_low", last_low, 34);

        // T4: reset during payload byte 100
        push_line(8'h25, 1'b0, 100);
        base = req_total;
        issue(2'b01, 3'd2 + 3'd3, 1'b0);
        for (int n = 0; n < 20000 && (req_total - base) < 101; n++) tick();
        chk("t4_reach_byte100", req_total - base, 101);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("t4_ss3", int'(ss_m), 1);
        chk("t4_sck", int'(sck_m), 0);
        chk("t4_data_req", int'(req_m), 0);
        reset = 1'b0;
        tick();
        chk("t4_ready", int'(ready_m), 1);
        chk("t4_bytes_left", exp_q.size(), 0);
        base = req_total;
        repeat (40) tick();
        chk("t4_no_fetch", req_total - base, 0);
        exp_q.push_back(8'h40);
        issue(2'b00, 3'd0, 1'b0);
        wait_idle();
        chk("t4_ss_low", last_low, 34);

        // T5: clear line 7, then reserved op
`ifdef OSD_TX_CLEAR_EN
        push_line(8'h27, 1'b1, 256);
        base = req_total;
        issue(2'b10, 3'd7, 1'b0);
        wait_idle();
        chk("t5_no_req", req_total - base, 0);
        chk("t5_ss_low", last_low, 8226);
`else
        drop_check(2'b10);
`endif
        drop_check(2'b11);

        // T6: CLK_DIV=1 write line 0
        sel = 1'b1;
        tick();
        chk("t6_ready", int'(ready_m), 1);
        push_line(8'h20, 1'b0, 256);
        base = req_total;
        issue(2'b01, 3'd0, 1'b0);
        wait_idle();
        chk("t6_req_count", req_total - base, 256);
        chk("t6_ss_low", last_low, 4625);

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
